// File: rtl/mem_map_pkg.sv
// Shared CPU memory-map constants: MMIO addresses and status register layout.
package mem_map_pkg;

    localparam logic [7:0] DEF_MMIO_STAT_ADDR = 8'hFE;
    localparam logic [7:0] DEF_MMIO_TX_ADDR   = 8'hFF;

    localparam int STAT_OVF     = 7;
    localparam int STAT_FULL    = 6;
    localparam int STAT_EMPTY   = 5;
    localparam int STAT_CNT_MSB = 4;
    localparam int STAT_CNT_LSB = 0;

    function automatic logic [7:0] pack_status(input logic ovf, input logic full,
                                               input logic empty, input logic [4:0] cnt);
        logic [7:0] s;
        s = '0;
        s[STAT_OVF]                  = ovf;
        s[STAT_FULL]                 = full;
        s[STAT_EMPTY]                = empty;
        s[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU bus, program loader and TX byte stream seen by the memory responder.
interface mem_responder_if #(parameter int M_WIDTH = 8);

    logic [M_WIDTH-1:0] addr;
    logic [M_WIDTH-1:0] data_in;
    logic               we;
    logic [M_WIDTH-1:0] data_out;
    logic               ld_en;
    logic               ld_start;
    logic               ld_valid;
    logic [M_WIDTH-1:0] ld_data;
    logic               ld_ready;
    logic               tx_valid;
    logic [M_WIDTH-1:0] tx_data;
    logic               tx_ready;

    modport master (
        output addr, data_in, we, ld_en, ld_start, ld_valid, ld_data, tx_ready,
        input  data_out, ld_ready, tx_valid, tx_data
    );

    modport slave (
        input  addr, data_in, we, ld_en, ld_start, ld_valid, ld_data, tx_ready,
        output data_out, ld_ready, tx_valid, tx_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// CPU-side RAM with TX byte port and status MMIO; an external loader owns the RAM port while ld_en is high.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int                 M_WIDTH        = 8,
    parameter int                 TX_DEPTH       = 8,
    parameter logic [M_WIDTH-1:0] MMIO_STAT_ADDR = M_WIDTH'(DEF_MMIO_STAT_ADDR),
    parameter logic [M_WIDTH-1:0] MMIO_TX_ADDR   = M_WIDTH'(DEF_MMIO_TX_ADDR)
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int CW = $clog2(TX_DEPTH + 1);

    logic [M_WIDTH-1:0] ram [2**M_WIDTH];
    logic [M_WIDTH-1:0] ld_ptr;
    logic [M_WIDTH-1:0] ram_addr;
    logic [M_WIDTH-1:0] ram_wdata;
    logic               ram_we;
    logic               is_stat;
    logic               is_tx;
    logic               cpu_wr;
    logic               push;
    logic               pop;
    logic               overflow;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [7:0]         status;

    assign is_stat = (bus.addr == MMIO_STAT_ADDR);
    assign is_tx   = (bus.addr == MMIO_TX_ADDR);
    assign cpu_wr  = bus.we && !bus.ld_en;
    assign push    = cpu_wr && is_tx;
    assign pop     = bus.tx_valid && bus.tx_ready;
    assign status  = pack_status(overflow, fifo_full, fifo_empty, 5'(fifo_count));

    assign bus.ld_ready = bus.ld_en;
    assign bus.tx_valid = !fifo_empty;

    // One RAM port: the loader addresses the full range, the CPU never writes the MMIO shadows.
    assign ram_we    = bus.ld_en ? bus.ld_valid : (cpu_wr && !is_stat && !is_tx);
    assign ram_addr  = bus.ld_en ? (bus.ld_start ? '0 : ld_ptr) : bus.addr;
    assign ram_wdata = bus.ld_en ? bus.ld_data : bus.data_in;

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[ram_addr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_out <= '0;
            ld_ptr       <= '0;
            overflow     <= 1'b0;
        end else begin
            if (bus.ld_en || is_tx) begin
                bus.data_out <= '0;
            end else if (is_stat) begin
                bus.data_out <= M_WIDTH'(status);
            end else begin
                bus.data_out <= ram[bus.addr];
            end

            if (bus.ld_start) begin
                ld_ptr <= (bus.ld_en && bus.ld_valid) ? M_WIDTH'(1) : '0;
            end else if (bus.ld_en && bus.ld_valid) begin
                ld_ptr <= ld_ptr + 1'b1;
            end

            if (cpu_wr && is_stat) begin
                overflow <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH(M_WIDTH),
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.data_in),
        .pop   (pop),
        .dout  (bus.tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
